// File: rtl/ahb_lite_sram_slave_pkg.sv
// Shared AHB-Lite encodings, FSM state type and byte-lane helper for the SRAM slave.
package ahb_lite_sram_slave_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic [2:0] HBURST_SINGLE = 3'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_t;

    // Little-endian lane enables; lane is the low two bits of the byte offset.
    function automatic logic [3:0] byte_lanes(input logic [2:0] size, input logic [1:0] lane);
        case (size)
            HSIZE_BYTE: byte_lanes = 4'b0001 << lane;
            HSIZE_HALF: byte_lanes = lane[1] ? 4'b1100 : 4'b0011;
            default:    byte_lanes = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/ahb_lite_sram_slave_if.sv
// AHB-Lite signal bundle between the decoder/mux fabric and the SRAM slave.
interface ahb_lite_sram_slave_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    logic        HMASTLOCK;
    logic        HREADY;
    logic [31:0] HWDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;

    modport slave (
        input  HSEL, HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADY, HWDATA,
        output HREADYOUT, HRESP, HRDATA
    );

    modport master (
        output HSEL, HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADY, HWDATA,
        input  HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/ahb_lite_slave_mem.sv
// Word-organised storage with per-byte write enables and combinational read.
module ahb_lite_slave_mem #(
    parameter int MEM_DEPTH = 256,
    parameter int AW        = $clog2(MEM_DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [3:0]    i_be,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [MEM_DEPTH];

    // Contents deliberately have no reset.
    always_ff @(posedge i_clk) begin
        for (int b = 0; b < 4; b++) begin
            if (i_we && i_be[b]) begin
                r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM responder: address-phase decode, wait-state/error FSM, byte-lane writes.
//
// state | meaning
// IDLE  | no data phase, or a legal data phase completing this cycle (r_valid)
// WAIT  | legal transfer stalled; r_cnt counts down to 0, then completes
// ERR1  | first ERROR cycle, HREADYOUT low
// ERR2  | second ERROR cycle, HREADYOUT high; a new transfer may be accepted
module ahb_lite_sram_slave
    import ahb_lite_sram_slave_pkg::*;
#(
    parameter int          MEM_DEPTH   = 256,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    ahb_lite_sram_slave_if.slave  s_ahb
);

    localparam int          AW        = $clog2(MEM_DEPTH);
    localparam logic [31:0] MEM_BYTES = 32'(4 * MEM_DEPTH);
    localparam logic [3:0]  WS_LOAD   = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t        r_state, w_state_nxt;
    logic [3:0]    r_cnt, w_cnt_nxt;
    logic          r_valid, w_valid_nxt;
    logic          r_write;
    logic [1:0]    r_size;
    logic [AW+1:0] r_offset;

    logic [31:0]   w_offset;
    logic          w_accept;
    logic          w_illegal;
    logic          w_capture;
    logic          w_complete;
    logic          w_hreadyout;
    logic          w_hresp;
    logic          w_we;
    logic [3:0]    w_be;
    logic [31:0]   w_rdata;
    logic          w_unused;

    assign w_offset  = s_ahb.HADDR - BASE_ADDR;
    assign w_accept  = s_ahb.HSEL & s_ahb.HREADY & s_ahb.HTRANS[1];
    assign w_illegal = (w_offset >= MEM_BYTES)
                     | (s_ahb.HSIZE > HSIZE_WORD)
                     | ((s_ahb.HSIZE == HSIZE_HALF) & s_ahb.HADDR[0])
                     | ((s_ahb.HSIZE == HSIZE_WORD) & (s_ahb.HADDR[1:0] != 2'b00));
    assign w_unused  = ^{s_ahb.HBURST, s_ahb.HPROT, s_ahb.HMASTLOCK};

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 4'd0;
            r_valid  <= 1'b0;
            r_write  <= 1'b0;
            r_size   <= 2'd0;
            r_offset <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_valid <= w_valid_nxt;
            if (w_capture) begin
                r_offset <= w_offset[AW+1:0];
                r_write  <= s_ahb.HWRITE;
                r_size   <= s_ahb.HSIZE[1:0];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_valid_nxt = r_valid;
        w_capture   = 1'b0;
        w_complete  = 1'b0;
        w_hreadyout = 1'b1;
        w_hresp     = HRESP_OKAY;
        case (r_state)
            ST_IDLE, ST_ERR2: begin
                w_complete = r_valid & (r_state == ST_IDLE);
                if (r_state == ST_ERR2) begin
                    w_hresp = HRESP_ERROR;
                end
                // A stalled bus (HREADY low) freezes everything, including a pending completion.
                if (s_ahb.HREADY) begin
                    w_state_nxt = ST_IDLE;
                    w_valid_nxt = 1'b0;
                    if (w_accept) begin
                        if (w_illegal) begin
                            w_state_nxt = ST_ERR1;
                        end else begin
                            w_valid_nxt = 1'b1;
                            w_capture   = 1'b1;
                            if (WAIT_STATES > 0) begin
                                w_state_nxt = ST_WAIT;
                                w_cnt_nxt   = WS_LOAD;
                            end
                        end
                    end
                end
            end
            ST_WAIT: begin
                w_hreadyout = 1'b0;
                if (r_cnt == 4'd0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            ST_ERR1: begin
                w_hreadyout = 1'b0;
                w_hresp     = HRESP_ERROR;
                w_state_nxt = ST_ERR2;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    assign w_we = w_complete & r_write & s_ahb.HREADY;
    assign w_be = byte_lanes({1'b0, r_size}, r_offset[1:0]);

    ahb_lite_slave_mem #(
        .MEM_DEPTH (MEM_DEPTH),
        .AW        (AW)
    ) u_mem (
        .i_clk   (HCLK),
        .i_we    (w_we),
        .i_be    (w_be),
        .i_addr  (r_offset[AW+1:2]),
        .i_wdata (s_ahb.HWDATA),
        .o_rdata (w_rdata)
    );

    assign s_ahb.HREADYOUT = w_hreadyout;
    assign s_ahb.HRESP     = w_hresp;
    assign s_ahb.HRDATA    = (w_complete & ~r_write) ? w_rdata : 32'h0;

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Directed bench: two slaves (0 and 3 wait states) on one shared bus with an AND-ed HREADY.
module tb_ahb_lite_sram_slave;
    import ahb_lite_sram_slave_pkg::*;

    logic        HCLK;
    logic        HRESETn;
    logic        t_dut;
    logic        t_hsel;
    logic [31:0] t_haddr;
    logic        t_hwrite;
    logic [2:0]  t_hsize;
    logic [1:0]  t_htrans;
    logic [31:0] t_hwdata;
    logic        t_hold_low;
    logic        w_hready;
    int          n_checks;
    int          n_fail;

    ahb_lite_sram_slave_if u_bus0 ();
    ahb_lite_sram_slave_if u_bus3 ();

    assign w_hready = u_bus0.HREADYOUT & u_bus3.HREADYOUT & ~t_hold_low;

    assign u_bus0.HSEL      = t_hsel & (t_dut == 1'b0);
    assign u_bus0.HADDR     = t_haddr;
    assign u_bus0.HWRITE    = t_hwrite;
    assign u_bus0.HSIZE     = t_hsize;
    assign u_bus0.HBURST    = HBURST_SINGLE;
    assign u_bus0.HPROT     = 4'b0011;
    assign u_bus0.HTRANS    = t_htrans;
    assign u_bus0.HMASTLOCK = 1'b0;
    assign u_bus0.HREADY    = w_hready;
    assign u_bus0.HWDATA    = t_hwdata;

    assign u_bus3.HSEL      = t_hsel & (t_dut == 1'b1);
    assign u_bus3.HADDR     = t_haddr;
    assign u_bus3.HWRITE    = t_hwrite;
    assign u_bus3.HSIZE     = t_hsize;
    assign u_bus3.HBURST    = HBURST_SINGLE;
    assign u_bus3.HPROT     = 4'b0011;
    assign u_bus3.HTRANS    = t_htrans;
    assign u_bus3.HMASTLOCK = 1'b0;
    assign u_bus3.HREADY    = w_hready;
    assign u_bus3.HWDATA    = t_hwdata;

    ahb_lite_sram_slave #(.MEM_DEPTH(256), .WAIT_STATES(0), .BASE_ADDR(32'h0)) u_dut0 (
        .HCLK(HCLK), .HRESETn(HRESETn), .s_ahb(u_bus0.slave)
    );
    ahb_lite_sram_slave #(.MEM_DEPTH(256), .WAIT_STATES(3), .BASE_ADDR(32'h0)) u_dut3 (
        .HCLK(HCLK), .HRESETn(HRESETn), .s_ahb(u_bus3.slave)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] cur_rdata();
        return (t_dut == 1'b1) ? u_bus3.HRDATA : u_bus0.HRDATA;
    endfunction
    function automatic logic [31:0] cur_ready();
        return {31'b0, (t_dut == 1'b1) ? u_bus3.HREADYOUT : u_bus0.HREADYOUT};
    endfunction
    function automatic logic [31:0] cur_resp();
        return {31'b0, (t_dut == 1'b1) ? u_bus3.HRESP : u_bus0.HRESP};
    endfunction

    task automatic go();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive_addr(input logic [31:0] a, input logic w, input logic [2:0] sz);
        t_hsel   = 1'b1;
        t_htrans = HTRANS_NONSEQ;
        t_haddr  = a;
        t_hwrite = w;
        t_hsize  = sz;
    endtask

    task automatic drive_idle();
        t_hsel   = 1'b0;
        t_htrans = HTRANS_IDLE;
    endtask

    task automatic wait_done(output int lows);
        lows = 0;
        while (w_hready !== 1'b1 && lows < 40) begin
            lows++;
            go();
        end
        if (lows >= 40) check_val("ready_timeout", {31'b0, w_hready}, 32'd1);
    endtask

    task automatic do_write(input logic dut, input logic [31:0] a, input logic [2:0] sz,
                            input logic [31:0] data, input int exp_lows);
        int lows;
        t_dut = dut;
        drive_addr(a, 1'b1, sz);
        go();
        t_hwdata = data;
        drive_idle();
        wait_done(lows);
        check_val("wr_wait_cycles", lows, exp_lows);
        check_val("wr_resp", cur_resp(), 32'd0);
        go();
    endtask

    task automatic do_read(input string tag, input logic dut, input logic [31:0] a,
                           input logic [31:0] exp, input int exp_lows);
        int lows;
        t_dut = dut;
        drive_addr(a, 1'b0, HSIZE_WORD);
        go();
        drive_idle();
        wait_done(lows);
        check_val({tag, "_wait_cycles"}, lows, exp_lows);
        check_val({tag, "_data"}, cur_rdata(), exp);
        check_val({tag, "_resp"}, cur_resp(), 32'd0);
        go();
        check_val({tag, "_rdata_after"}, cur_rdata(), 32'd0);
    endtask

    // Illegal access, then a read issued during ERR2 that must complete OKAY.
    task automatic do_err(input string tag, input logic dut, input logic [31:0] a,
                          input logic [2:0] sz, input logic w,
                          input logic [31:0] fol_addr, input logic [31:0] fol_exp);
        int lows;
        t_dut = dut;
        drive_addr(a, w, sz);
        go();
        t_hwdata = 32'hFFFF_FFFF;
        drive_idle();
        check_val({tag, "_err1_ready"}, cur_ready(), 32'd0);
        check_val({tag, "_err1_resp"},  cur_resp(),  32'd1);
        check_val({tag, "_err1_rdata"}, cur_rdata(), 32'd0);
        go();
        check_val({tag, "_err2_ready"}, cur_ready(), 32'd1);
        check_val({tag, "_err2_resp"},  cur_resp(),  32'd1);
        check_val({tag, "_err2_rdata"}, cur_rdata(), 32'd0);
        drive_addr(fol_addr, 1'b0, HSIZE_WORD);
        go();
        drive_idle();
        wait_done(lows);
        check_val({tag, "_follow_data"}, cur_rdata(), fol_exp);
        check_val({tag, "_follow_resp"}, cur_resp(),  32'd0);
        go();
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        t_dut      = 1'b0;
        t_hsel     = 1'b0;
        t_haddr    = 32'h0;
        t_hwrite   = 1'b0;
        t_hsize    = HSIZE_WORD;
        t_htrans   = HTRANS_IDLE;
        t_hwdata   = 32'h0;
        t_hold_low = 1'b0;
        HRESETn    = 1'b0;
        #12;
        check_val("rst_ready0", {31'b0, u_bus0.HREADYOUT}, 32'd1);
        check_val("rst_resp0",  {31'b0, u_bus0.HRESP},     32'd0);
        check_val("rst_rdata0", u_bus0.HRDATA,             32'd0);
        check_val("rst_ready3", {31'b0, u_bus3.HREADYOUT}, 32'd1);
        HRESETn = 1'b1;
        go();

        // Zero wait states: word write then read.
        do_write(1'b0, 32'h10, HSIZE_WORD, 32'hDEAD_BEEF, 0);
        do_read("t1_rd", 1'b0, 32'h10, 32'hDEAD_BEEF, 0);

        // Byte and halfword lane merging.
        do_write(1'b0, 32'h10, HSIZE_WORD, 32'h1122_3344, 0);
        do_write(1'b0, 32'h13, HSIZE_BYTE, 32'hAA00_0000, 0);
        do_read("t2_byte", 1'b0, 32'h10, 32'hAA22_3344, 0);
        do_write(1'b0, 32'h10, HSIZE_HALF, 32'h0000_5566, 0);
        do_read("t2_half", 1'b0, 32'h10, 32'hAA22_5566, 0);

        // Last legal word.
        do_write(1'b0, 32'h3FC, HSIZE_WORD, 32'h55AA_55AA, 0);
        do_read("t2_top", 1'b0, 32'h3FC, 32'h55AA_55AA, 0);

        // Three wait states.
        do_write(1'b1, 32'h40, HSIZE_WORD, 32'hCAFE_BABE, 3);
        do_read("t3_rd", 1'b1, 32'h40, 32'hCAFE_BABE, 3);
        do_write(1'b1, 32'h41, HSIZE_BYTE, 32'h0000_BB00, 3);
        do_write(1'b1, 32'h42, HSIZE_HALF, 32'h1234_0000, 3);
        do_read("t3_lanes", 1'b1, 32'h40, 32'h1234_BBBE, 3);

        // Error responses; word 0 must stay untouched.
        do_write(1'b0, 32'h00, HSIZE_WORD, 32'h0BAD_F00D, 0);
        do_err("t4_misalign", 1'b0, 32'h02,  HSIZE_WORD, 1'b1, 32'h00, 32'h0BAD_F00D);
        do_err("t4_range",    1'b0, 32'h400, HSIZE_WORD, 1'b1, 32'h00, 32'h0BAD_F00D);
        do_err("t4_half_odd", 1'b0, 32'h11,  HSIZE_HALF, 1'b1, 32'h10, 32'hAA22_5566);
        do_err("t4_size3",    1'b0, 32'h10,  3'd3,       1'b0, 32'h10, 32'hAA22_5566);
        do_err("t4_ws3",      1'b1, 32'h41,  HSIZE_WORD, 1'b1, 32'h40, 32'h1234_BBBE);

        // Back-to-back write then read of the same word.
        t_dut = 1'b0;
        drive_addr(32'h20, 1'b1, HSIZE_WORD);
        go();
        t_hwdata = 32'h1234_5678;
        drive_addr(32'h20, 1'b0, HSIZE_WORD);
        check_val("t5_wr_ready", cur_ready(), 32'd1);
        go();
        drive_idle();
        check_val("t5_rd_ready", cur_ready(), 32'd1);
        check_val("t5_rd_data",  cur_rdata(), 32'h1234_5678);
        check_val("t5_rd_resp",  cur_resp(),  32'd0);
        go();

        // BUSY with HSEL high starts nothing.
        t_hsel   = 1'b1;
        t_htrans = HTRANS_BUSY;
        t_haddr  = 32'h10;
        t_hwrite = 1'b0;
        go();
        drive_idle();
        check_val("busy_ready", cur_ready(), 32'd1);
        check_val("busy_rdata", cur_rdata(), 32'd0);

        // Reset during the WAIT of a write aborts it.
        do_write(1'b1, 32'h30, HSIZE_WORD, 32'h1111_1111, 3);
        drive_addr(32'h30, 1'b1, HSIZE_WORD);
        go();
        t_hwdata = 32'h9999_9999;
        drive_idle();
        go();
        check_val("t6_in_wait", cur_ready(), 32'd0);
        #1 HRESETn = 1'b0;
        #1;
        check_val("t6_rst_ready", cur_ready(), 32'd1);
        check_val("t6_rst_resp",  cur_resp(),  32'd0);
        check_val("t6_rst_rdata", cur_rdata(), 32'd0);
        #1 HRESETn = 1'b1;
        go();
        do_read("t6_keep", 1'b1, 32'h30, 32'h1111_1111, 3);

        // HSEL with HREADY held low by another slave.
        t_hold_low = 1'b1;
        t_dut = 1'b1;
        drive_addr(32'h30, 1'b0, HSIZE_WORD);
        go();
        check_val("t6_hold_ready3", cur_ready(), 32'd1);
        t_dut = 1'b0;
        drive_addr(32'h10, 1'b0, HSIZE_WORD);
        go();
        check_val("t6_hold_rdata0", cur_rdata(), 32'd0);
        t_hold_low = 1'b0;
        drive_idle();
        #1;
        check_val("t6_release_rdata0", cur_rdata(), 32'd0);
        go();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
